msrv32_ahb_ifetch_buf: RTL and testbench
========================================

MSRV32_AHB_IFETCH_BUF -- requirements
Module: msrv32_ahb_ifetch_buf

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-004 SHALL have port ms_riscv32_mp_clk_in  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port ms_riscv32_mp_rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port ms_riscv32_mp_imaddr_out  output  XLEN  AHB-Lite instruction address-phase address.
REQ-007 SHALL have port ms_riscv32_mp_itrans_out  output  1  1 = NONSEQ address phase requested, 0 = IDLE.
REQ-008 SHALL have port ms_riscv32_mp_instr_in  input  XLEN  AHB-Lite read data.
REQ-009 SHALL have port ms_riscv32_mp_instr_hready_in  input  1  AHB-Lite HREADY, transfer completion.
REQ-010 SHALL have port ms_riscv32_mp_redirect_in  input  1  branch/trap redirect strobe.
REQ-011 SHALL have port ms_riscv32_mp_redirect_pc_in  input  XLEN  redirect target, word aligned.
REQ-012 SHALL have port ms_riscv32_mp_instr_out  output  XLEN  FIFO head instruction.
REQ-013 SHALL have port ms_riscv32_mp_instr_pc_out  output  XLEN  PC of FIFO head.
REQ-014 SHALL have port ms_riscv32_mp_instr_valid_out  output  1  FIFO head valid.
REQ-015 SHALL have port ms_riscv32_mp_instr_ready_in  input  1  core accepts head.
REQ-016 SHALL have port ms_riscv32_mp_level_out  output  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-017 SHALL update imaddr_out and itrans_out only at edges where hready=1; both held stable during wait states.
REQ-018 SHALL complete an address phase at an edge with itrans_out=1 and hready=1: fetch PC += 4 (mod 2^XLEN, wrap), one data phase pending tagged with that PC.
REQ-019 SHALL complete a pending data phase at the next edge with hready=1, pushing {instr_in, tag PC} unless flagged discard.
REQ-020 SHALL support one address phase overlapping one data phase (pipelined AHB-Lite); at most one data phase pending.
REQ-021 SHALL set itrans_out at an hready=1 edge iff (level after this edge + data phases pending after this edge) < DEPTH, guaranteeing no push into a full FIFO.
REQ-022 SHALL assert instr_valid_out iff level != 0; pop on valid & ready; instruction order preserved.
REQ-023 SHALL allow push and pop in same cycle with level unchanged.
REQ-024 SHALL, on redirect_in=1 at an edge with hready=1: clear FIFO (level=0), discard any data phase completing that edge and any address phase completing that edge, load fetch PC with redirect_pc_in; pop ignored.
REQ-025 SHALL, on redirect_in=1 at an edge with hready=0: clear FIFO, flag stalled transfers discard, store target; apply target at next hready=1 edge; a later redirect before then overwrites stored target.
REQ-026 SHALL never present a discarded or post-flush-stale instruction on instr_out.
REQ-027 SHALL drive level_out as exact registered occupancy, 0..DEPTH.

Reset
REQ-028 SHALL, while rst_n_in=0: imaddr_out=RESET_PC, itrans_out=0, instr_valid_out=0, level_out=0, instr_out=0, instr_pc_out=0, no pending/discard/redirect state.
REQ-029 SHALL assert itrans_out with imaddr_out=RESET_PC at first edge after reset release with hready=1.
REQ-030 SHALL abandon all in-flight transfers on reset assertion mid-operation; no returning data is ever pushed.

Verification
REQ-031 Reset release, hready=1, ready=1, memory returns addr+0xA000 -> instr_out sequence 0xA000/PC 0, 0xA004/PC 4, 0xA008/PC 8, one instruction per cycle after 2-cycle latency.
REQ-032 DEPTH=4, ready=0, hready=1 -> level_out stops at 4, itrans_out=0, no further address phases; ready=1 for one cycle -> level 3, one new fetch issued.
REQ-033 hready=0 for 3 cycles mid-stream -> imaddr_out and itrans_out unchanged throughout, no push, no lost or duplicated PC.
REQ-034 Redirect to 0x100 with level=3 and data phase in flight, hready=1 -> level 0 next cycle, in-flight word discarded, next imaddr_out=0x100, first valid PC=0x100.
REQ-035 Redirect to 0x200 during wait state, then redirect to 0x300 before hready=1 -> stalled transfer discarded, next fetch address 0x300, no 0x200 fetch.
REQ-036 Fetch PC 0xFFFF_FFFC -> next imaddr_out=0x0000_0000 (wrap).

Source files
------------

// File: rtl/msrv32_ahb_ifetch_buf.sv
// AHB-Lite instruction prefetch buffer.
// Address phases are issued ahead of the core into a small FIFO. One data
// phase may overlap one address phase. Redirects flush the FIFO and discard
// any transfer already on the bus. A redirect taken during a wait state is
// parked until the next HREADY edge, and a later redirect overwrites it.
module msrv32_ahb_ifetch_buf #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         ms_riscv32_mp_clk_in,
  input  logic                         ms_riscv32_mp_rst_n_in,
  output logic [XLEN-1:0]              ms_riscv32_mp_imaddr_out,
  output logic                         ms_riscv32_mp_itrans_out,
  input  logic [XLEN-1:0]              ms_riscv32_mp_instr_in,
  input  logic                         ms_riscv32_mp_instr_hready_in,
  input  logic                         ms_riscv32_mp_redirect_in,
  input  logic [XLEN-1:0]              ms_riscv32_mp_redirect_pc_in,
  output logic [XLEN-1:0]              ms_riscv32_mp_instr_out,
  output logic [XLEN-1:0]              ms_riscv32_mp_instr_pc_out,
  output logic                         ms_riscv32_mp_instr_valid_out,
  input  logic                         ms_riscv32_mp_instr_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   ms_riscv32_mp_level_out
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic            hready;
  logic            redirect;
  logic            addr_done;
  logic            push;
  logic            pop;
  logic [LW:0]     level_nxt;
  logic [LW:0]     occ_nxt;
  logic            dph_vld_nxt;
  logic            itrans_nxt;
  logic [XLEN-1:0] pc_nxt;

  // data-phase tracking: valid is control, the tag PC is datapath
  logic            dph_vld_p1;
  logic [XLEN-1:0] dph_pc_p1;

  // parked redirect taken during a wait state
  logic            redir_vld;
  logic [XLEN-1:0] redir_pc;

  // FIFO storage and control
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [LW-1:0]   level;

  assign hready   = ms_riscv32_mp_instr_hready_in;
  assign redirect = ms_riscv32_mp_redirect_in;

  // Next-state of the bus pipeline and FIFO occupancy for this edge.
  always_comb begin
    addr_done   = hready & ms_riscv32_mp_itrans_out;
    // any flush (live or parked) kills both the completing data phase and
    // the completing address phase
    push        = hready & dph_vld_p1 & ~redirect & ~redir_vld;
    pop         = ms_riscv32_mp_instr_valid_out & ms_riscv32_mp_instr_ready_in & ~redirect;
    if (redirect)
      level_nxt = '0;
    else
      level_nxt = {1'b0, level} + (LW+1)'(push) - (LW+1)'(pop);
    if (hready)
      dph_vld_nxt = addr_done & ~redirect & ~redir_vld;
    else
      dph_vld_nxt = dph_vld_p1;
    occ_nxt     = level_nxt + (LW+1)'(dph_vld_nxt);
    // only issue if every outstanding word is guaranteed a free slot
    if (hready)
      itrans_nxt = (occ_nxt < (LW+1)'(DEPTH));
    else
      itrans_nxt = ms_riscv32_mp_itrans_out;
    pc_nxt      = ms_riscv32_mp_imaddr_out;
    if (hready) begin
      if (redirect)
        pc_nxt = ms_riscv32_mp_redirect_pc_in;
      else if (redir_vld)
        pc_nxt = redir_pc;
      else if (addr_done)
        pc_nxt = ms_riscv32_mp_imaddr_out + XLEN'(4);
    end
  end

  // Bus-side control state: address phase, data-phase valid, parked redirect.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      ms_riscv32_mp_imaddr_out <= RESET_PC;
      ms_riscv32_mp_itrans_out <= 1'b0;
      dph_vld_p1               <= 1'b0;
      redir_vld                <= 1'b0;
    end else begin
      ms_riscv32_mp_imaddr_out <= pc_nxt;
      ms_riscv32_mp_itrans_out <= itrans_nxt;
      dph_vld_p1               <= dph_vld_nxt;
      if (redirect && !hready)
        redir_vld <= 1'b1;
      else if (hready)
        redir_vld <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_nxt[LW-1:0];
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + PW'(pop);
        wr_ptr <= wr_ptr + PW'(push);
      end
    end
  end

  // Datapath registers: data-phase tag, parked target and FIFO payload.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (addr_done)
      dph_pc_p1 <= ms_riscv32_mp_imaddr_out;
    if (redirect && !hready)
      redir_pc <= ms_riscv32_mp_redirect_pc_in;
    if (push) begin
      mem_instr[wr_ptr] <= ms_riscv32_mp_instr_in;
      mem_pc[wr_ptr]    <= dph_pc_p1;
    end
  end

  // Head presentation; zero while empty so stale entries never leak out.
  always_comb begin
    ms_riscv32_mp_instr_valid_out = (level != '0);
    ms_riscv32_mp_level_out       = level;
    ms_riscv32_mp_instr_out       = '0;
    ms_riscv32_mp_instr_pc_out    = '0;
    if (level != '0) begin
      ms_riscv32_mp_instr_out    = mem_instr[rd_ptr];
      ms_riscv32_mp_instr_pc_out = mem_pc[rd_ptr];
    end
  end

endmodule

// File: tb/tb_msrv32_ahb_ifetch_buf.sv
// Directed bench for the instruction prefetch buffer with a simple
// AHB-Lite slave (data = address + 0xA000) and an expected-PC queue.
module tb_msrv32_ahb_ifetch_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imaddr;
  logic        itrans;
  logic [31:0] instr_in;
  logic        hready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        valid;
  logic        ready;
  logic [2:0]  level;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;

  logic [31:0] exp_q[$];
  logic [31:0] dph_addr;
  logic        seen_200 = 1'b0;

  msrv32_ahb_ifetch_buf #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .ms_riscv32_mp_clk_in          (clk),
    .ms_riscv32_mp_rst_n_in        (rst_n),
    .ms_riscv32_mp_imaddr_out      (imaddr),
    .ms_riscv32_mp_itrans_out      (itrans),
    .ms_riscv32_mp_instr_in        (instr_in),
    .ms_riscv32_mp_instr_hready_in (hready),
    .ms_riscv32_mp_redirect_in     (redirect),
    .ms_riscv32_mp_redirect_pc_in  (redirect_pc),
    .ms_riscv32_mp_instr_out       (instr_out),
    .ms_riscv32_mp_instr_pc_out    (instr_pc),
    .ms_riscv32_mp_instr_valid_out (valid),
    .ms_riscv32_mp_instr_ready_in  (ready),
    .ms_riscv32_mp_level_out       (level)
  );

  always #5 clk = ~clk;

  // AHB-Lite slave: latch the accepted address, return addr+0xA000 in the data phase
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dph_addr <= 32'h0;
    else if (hready) begin
      dph_addr <= imaddr;
      if (itrans && imaddr == 32'h200) seen_200 <= 1'b1;
    end
  end
  assign instr_in = dph_addr + 32'hA000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_expect(input logic [31:0] start);
    logic [31:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < 128; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // scoreboard: every head accepted by the core must be the next expected PC
  always @(negedge clk) begin
    if (rst_n && valid && ready && !redirect) begin
      logic [31:0] e;
      pops++;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr_out, e + 32'hA000);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic        t;
    logic [2:0]  l;
    bit          found;

    rst_n = 1'b0; hready = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    load_expect(32'h0);
    repeat (2) tick();
    chk("rst_imaddr", imaddr, 32'h0);
    chk("rst_itrans", {31'b0, itrans}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_level", {29'b0, level}, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);

    // reset release and streaming
    rst_n = 1'b1;
    tick();
    chk("first_itrans", {31'b0, itrans}, 32'h1);
    chk("first_imaddr", imaddr, 32'h0);
    tick();
    tick();
    chk("lat_valid", {31'b0, valid}, 32'h1);
    chk("lat_pc", instr_pc, 32'h0);
    chk("lat_instr", instr_out, 32'hA000);
    repeat (8) tick();
    chk("stream_level", {29'b0, level}, 32'h1);

    // fill to DEPTH with core stalled
    ready = 1'b0;
    repeat (10) tick();
    chk("full_level", {29'b0, level}, 32'h4);
    chk("full_itrans", {31'b0, itrans}, 32'h0);
    a = imaddr;
    repeat (3) tick();
    chk("full_addr_hold", imaddr, a);
    chk("full_level_hold", {29'b0, level}, 32'h4);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("pop1_level", {29'b0, level}, 32'h3);
    chk("pop1_itrans", {31'b0, itrans}, 32'h1);
    tick();
    chk("pop1b_level", {29'b0, level}, 32'h3);
    chk("pop1b_itrans", {31'b0, itrans}, 32'h0);
    tick();
    chk("refill_level", {29'b0, level}, 32'h4);

    // wait states mid-stream
    ready = 1'b1;
    repeat (6) tick();
    ready = 1'b0; hready = 1'b0;
    a = imaddr; t = itrans; l = level;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_imaddr", imaddr, a);
      chk("ws_itrans", {31'b0, itrans}, {31'b0, t});
      chk("ws_level", {29'b0, level}, {29'b0, l});
    end
    hready = 1'b1; ready = 1'b1;
    repeat (6) tick();

    // redirect with level 3 and a data phase in flight
    ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (level == 3'd3) found = 1'b1;
      else tick();
    end
    chk("wait_level3", {31'b0, found}, 32'h1);
    chk("pre_redir_itrans", {31'b0, itrans}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100; ready = 1'b1;
    load_expect(32'h100);
    tick();
    redirect = 1'b0;
    chk("redir_level", {29'b0, level}, 32'h0);
    chk("redir_valid", {31'b0, valid}, 32'h0);
    chk("redir_imaddr", imaddr, 32'h100);
    chk("redir_itrans", {31'b0, itrans}, 32'h1);
    repeat (8) tick();

    // double redirect during a wait state
    hready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    exp_q.delete();
    tick();
    chk("ws_redir_level", {29'b0, level}, 32'h0);
    chk("ws_redir_valid", {31'b0, valid}, 32'h0);
    redirect_pc = 32'h300;
    load_expect(32'h300);
    tick();
    redirect = 1'b0;
    tick();
    hready = 1'b1;
    tick();
    chk("ws_redir_imaddr", imaddr, 32'h300);
    chk("ws_redir_itrans", {31'b0, itrans}, 32'h1);
    repeat (8) tick();
    chk("no_fetch_200", {31'b0, seen_200}, 32'h0);

    // address wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    load_expect(32'hFFFF_FFF8);
    tick();
    redirect = 1'b0;
    chk("wrap_a0", imaddr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_a1", imaddr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_a2", imaddr, 32'h0000_0000);
    repeat (6) tick();

    // reset mid-stream abandons in-flight transfers
    rst_n = 1'b0;
    #1;
    chk("mrst_itrans", {31'b0, itrans}, 32'h0);
    chk("mrst_valid", {31'b0, valid}, 32'h0);
    chk("mrst_level", {29'b0, level}, 32'h0);
    chk("mrst_imaddr", imaddr, 32'h0);
    load_expect(32'h0);
    tick();
    rst_n = 1'b1;
    repeat (10) tick();

    chk("pops_enough", {31'b0, (pops >= 30)}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
